// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: the word is accepted over valid/ready and sent one bit per clock.
// The first bit appears one cycle after acceptance; `define PISO_PARITY_EN appends an even-parity bit.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FL - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             at_last;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  // shreg holds only the bits not yet sent, with the next one at the output end
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign at_last = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign accept  = din_valid && din_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
`ifdef PISO_PARITY_EN
    par_d   = accept ? ^din : par_q;
`endif
    if (accept) begin
      state_d = SHIFT;
      cnt_d   = '0;
      shreg_d = advance(din);
    end else if (state_q == SHIFT) begin
      if (at_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        shreg_d = advance(shreg_q);
      end
    end
  end

  always_comb begin
    din_ready = !rst && ((state_q == IDLE) || at_last);
    sout_d    = 1'b0;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    busy_d    = 1'b0;
    if (accept) begin
      sout_d  = head_bit(din);
      valid_d = 1'b1;
      busy_d  = 1'b1;
    end else if ((state_q == SHIFT) && !at_last) begin
      valid_d = 1'b1;
      busy_d  = 1'b1;
      last_d  = (cnt_d == LAST_CNT);
      sout_d  = head_bit(shreg_q);
`ifdef PISO_PARITY_EN
      if (cnt_q == CW'(WIDTH - 1)) sout_d = par_q;
`endif
    end
  end

  assign sout       = sout_q;
  assign sout_valid = valid_q;
  assign sout_last  = last_q;
  assign busy       = busy_q;

endmodule
